wb_writeback_unit: RTL

Writeback stage directly upstream of the register file. It collects results from the single-cycle ALU and from the load path, formats load data, arbitrates between the two sources and drives the register file write port (write, write_add, data_received). It also keeps a per-register pending-load scoreboard for the hazard logic.

---
 rtl/wb_writeback_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/wb_writeback_unit.sv
// Writeback stage: formats load data, arbitrates load/ALU/skid results onto the register file write port,
// and tracks outstanding loads in busy_mask. Write port is registered, 1 cycle after accept / mem_rvalid.
// Optional macro WB_BYPASS_EN adds a combinational forwarding path from the registered write port.
module wb_writeback_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_rd,
  input  logic [XLEN-1:0]         alu_result,
  input  logic                    ld_issue,
  output logic                    ld_ready,
  input  logic [4:0]              ld_rd,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_addr_lo,
  input  logic                    mem_rvalid,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic                    write,
  output logic [4:0]              write_add,
  output logic signed [XLEN-1:0]  data_received,
`ifdef WB_BYPASS_EN
  input  logic [4:0]              src_add1,
  input  logic [4:0]              src_add2,
  output logic                    byp_hit1,
  output logic                    byp_hit2,
  output logic [XLEN-1:0]         byp_data1,
  output logic [XLEN-1:0]         byp_data2,
`endif
  output logic [NREGS-1:0]        busy_mask
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} ld_state_t;

  ld_state_t        ld_state;
  ld_state_t        ld_state_n;
  logic [4:0]       ld_rd_q;
  logic [2:0]       ld_f3_q;
  logic [1:0]       ld_lo_q;
  logic             skid_vld;
  logic             skid_vld_n;
  logic [4:0]       skid_rd;
  logic [XLEN-1:0]  skid_dat;
  logic             ld_done;
  logic             alu_acc;
  logic             ld_acc;
  logic             com_vld;
  logic [4:0]       com_rd;
  logic [XLEN-1:0]  com_dat;
  logic [XLEN-1:0]  ld_fmt;

  // Extract and extend the addressed byte/halfword; halfwords only look at the upper lane bit.
  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  assign ld_done = mem_rvalid & (ld_state == WAIT);
  assign alu_acc = alu_valid & alu_ready;
  assign ld_acc  = ld_issue & ld_ready;
  assign ld_fmt  = fmt_load(ld_f3_q, ld_lo_q, mem_rdata);

  // Pick this cycle's committing result: load completion, then skid entry, then a fresh ALU result.
  always_comb begin
    com_vld = 1'b0;
    com_rd  = '0;
    com_dat = '0;
    if (ld_done) begin
      com_vld = 1'b1;
      com_rd  = ld_rd_q;
      com_dat = ld_fmt;
    end else if (skid_vld) begin
      com_vld = 1'b1;
      com_rd  = skid_rd;
      com_dat = skid_dat;
    end else if (alu_acc) begin
      com_vld = 1'b1;
      com_rd  = alu_rd;
      com_dat = alu_result;
    end
  end

  // The skid only fills when a load completes alongside a new ALU result; it drains whenever no load completes.
  assign skid_vld_n = ld_done & (skid_vld | alu_acc);
  assign ld_state_n = ld_acc ? WAIT : (ld_done ? IDLE : ld_state);

  // Load tracker FSM, skid buffer, busy scoreboard, ready flags and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state      <= IDLE;
      ld_rd_q       <= '0;
      ld_f3_q       <= '0;
      ld_lo_q       <= '0;
      skid_vld      <= 1'b0;
      skid_rd       <= '0;
      skid_dat      <= '0;
      alu_ready     <= 1'b1;
      ld_ready      <= 1'b1;
      write         <= 1'b0;
      write_add     <= '0;
      data_received <= '0;
      busy_mask     <= '0;
    end else begin
      case (ld_state)
        IDLE: if (ld_acc) begin
          ld_state <= WAIT;
          ld_rd_q  <= ld_rd;
          ld_f3_q  <= ld_funct3;
          ld_lo_q  <= ld_addr_lo;
        end
        WAIT: if (mem_rvalid) ld_state <= IDLE;
        default: ld_state <= IDLE;
      endcase

      // Set and clear never coincide: a new load is only accepted while idle.
      if (ld_acc && (ld_rd != 5'd0)) busy_mask[ld_rd] <= 1'b1;
      if (ld_done) busy_mask[ld_rd_q] <= 1'b0;

      skid_vld <= skid_vld_n;
      if (ld_done && alu_acc) begin
        skid_rd  <= alu_rd;
        skid_dat <= alu_result;
      end

      alu_ready <= ~skid_vld_n;
      ld_ready  <= (ld_state_n == IDLE) & ~skid_vld_n;

      // x0 results use their slot but never pulse the write enable.
      write <= com_vld & (com_rd != 5'd0);
      if (com_vld && (com_rd != 5'd0)) begin
        write_add     <= com_rd;
        data_received <= com_dat;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the write currently being presented to same-cycle register reads.
  always_comb begin
    byp_hit1  = write & (write_add == src_add1) & (src_add1 != 5'd0);
    byp_hit2  = write & (write_add == src_add2) & (src_add2 != 5'd0);
    byp_data1 = byp_hit1 ? data_received : '0;
    byp_data2 = byp_hit2 ? data_received : '0;
  end
`endif

endmodule
